// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter, its three requesters and the system RAM.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_we;
  logic              cpu_sync;
  logic              cpu_rdy;
  logic [7:0]        cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [7:0]        vga_rdata;

  logic              uart_req;
  logic [ADDR_W-1:0] uart_addr;
  logic [7:0]        uart_wdata;
  logic              uart_we;
  logic              uart_gnt;

  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        ram_dout;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_sync,
    input  vga_req, vga_addr,
    input  uart_req, uart_addr, uart_wdata, uart_we,
    input  ram_dout,
    output cpu_rdy, cpu_rdata,
    output vga_gnt, vga_rvalid, vga_rdata,
    output uart_gnt,
    output ram_raddr, ram_waddr, ram_din, ram_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_sync,
    output vga_req, vga_addr,
    output uart_req, uart_addr, uart_wdata, uart_we,
    output ram_dout,
    input  cpu_rdy, cpu_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  uart_gnt,
    input  ram_raddr, ram_waddr, ram_din, ram_we
  );
endinterface

// File: rtl/ram_arbiter.sv
// Time-shares the system RAM between the 6502 core (default owner), the VGA
// renderer and the UART loader; the CPU is paused only at instruction boundaries.
module ram_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int SYNC_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_RST,
    ST_RUN,
    ST_WAIT_SYNC,
    ST_VGA,
    ST_UART
  } state_e;

  localparam logic [7:0] WD_LAST = 8'(SYNC_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic       cpu_rdy_q, cpu_rdy_d;
  logic       vga_gnt_q, vga_gnt_d;
  logic       uart_gnt_q, uart_gnt_d;
  logic       vga_rvalid_q, vga_rvalid_d;

  logic   pending;
  state_e grant_pick;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    wd_d       = '0;
    pending    = bus.vga_req | bus.uart_req;
    grant_pick = bus.vga_req ? ST_VGA : ST_UART;

    case (state_q)
      ST_RST: state_d = ST_RUN;
      ST_RUN: begin
        if (pending) state_d = bus.cpu_sync ? grant_pick : ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        // Priority is re-evaluated on the leaving cycle; the watchdog only counts while staying.
        if (!pending)                             state_d = ST_RUN;
        else if (bus.cpu_sync || wd_q == WD_LAST) state_d = grant_pick;
        else                                      wd_d    = wd_q + 8'd1;
      end
      ST_VGA: begin
        if (!bus.vga_req) state_d = bus.uart_req ? ST_UART : ST_RUN;
      end
      ST_UART: begin
        if (!bus.uart_req) state_d = bus.vga_req ? ST_VGA : ST_RUN;
      end
      default: state_d = ST_RST;
    endcase

    cpu_rdy_d    = (state_d == ST_RUN) || (state_d == ST_WAIT_SYNC);
    vga_gnt_d    = (state_d == ST_VGA);
    uart_gnt_d   = (state_d == ST_UART);
    vga_rvalid_d = vga_gnt_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= ST_RST;
      wd_q         <= '0;
      cpu_rdy_q    <= 1'b0;
      vga_gnt_q    <= 1'b0;
      uart_gnt_q   <= 1'b0;
      vga_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      cpu_rdy_q    <= cpu_rdy_d;
      vga_gnt_q    <= vga_gnt_d;
      uart_gnt_q   <= uart_gnt_d;
      vga_rvalid_q <= vga_rvalid_d;
    end
  end

  // RAM steering follows the registered owner so the muxes never glitch on a request edge.
  always_comb begin
    bus.ram_raddr = bus.cpu_addr;
    bus.ram_waddr = bus.cpu_addr;
    bus.ram_din   = bus.cpu_wdata;
    bus.ram_we    = 1'b0;
    case (state_q)
      ST_RUN, ST_WAIT_SYNC: bus.ram_we = bus.cpu_we;
      ST_VGA:               bus.ram_raddr = bus.vga_addr;
      ST_UART: begin
        bus.ram_raddr = bus.uart_addr;
        bus.ram_waddr = bus.uart_addr;
        bus.ram_din   = bus.uart_wdata;
        bus.ram_we    = bus.uart_we;
      end
      default: bus.ram_we = 1'b0;
    endcase
  end

  assign bus.cpu_rdy    = cpu_rdy_q;
  assign bus.vga_gnt    = vga_gnt_q;
  assign bus.uart_gnt   = uart_gnt_q;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.cpu_rdata  = bus.ram_dout;
  assign bus.vga_rdata  = bus.ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table, hand-written corner sequences
// and a randomized run checking grant exclusivity and write legality.
module tb_ram_arbiter;

  localparam int ADDR_W = 11;

  logic clk;
  logic reset;

  ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ram_arbiter #(.ADDR_W(ADDR_W), .SYNC_TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_raddr];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, sync, vreq, ureq, cwe, uwe;
    logic rdy, vg, ug, rv, we;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int n;
    logic ok;

    reset          = 1'b1;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_we     = 1'b0;
    bus.cpu_sync   = 1'b0;
    bus.vga_req    = 1'b0;
    bus.vga_addr   = '0;
    bus.uart_req   = 1'b0;
    bus.uart_addr  = '0;
    bus.uart_wdata = '0;
    bus.uart_we    = 1'b0;

    // rst sync vreq ureq cwe uwe | rdy vg ug rv we
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0};

    // Reset for 3 cycles, then release
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rdy", bus.cpu_rdy, 0);
      check("rst_gnts", {bus.vga_gnt, bus.uart_gnt, bus.vga_rvalid}, 0);
    end
    bus.cpu_we = 1'b1;
    #1 check("rst_ram_we", bus.ram_we, 0);
    bus.cpu_we = 1'b0;
    reset = 1'b0;
    tick();
    check("rel_rdy", bus.cpu_rdy, 1);
    check("rel_gnts", {bus.vga_gnt, bus.uart_gnt}, 0);
    bus.cpu_we = 1'b1;
    #1 check("run_we1", bus.ram_we, 1);
    bus.cpu_we = 1'b0;
    #1 check("run_we0", bus.ram_we, 0);

    // CPU stores 0xA5 at 0x200 for the VGA read below
    bus.cpu_addr = 11'h200; bus.cpu_wdata = 8'hA5; bus.cpu_we = 1'b1;
    tick();
    bus.cpu_we = 1'b0;

    // VGA request waits 5 cycles for SYNC
    bus.vga_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ws_rdy", bus.cpu_rdy, 1);
      check("ws_vgnt", bus.vga_gnt, 0);
    end
    bus.cpu_sync = 1'b1;
    tick();
    check("vg_rdy", bus.cpu_rdy, 0);
    check("vg_gnt", bus.vga_gnt, 1);
    bus.cpu_sync = 1'b0;
    bus.vga_addr = 11'h200;
    tick();
    check("vg_rvalid", bus.vga_rvalid, 1);
    check("vg_rdata", bus.vga_rdata, 8'hA5);
    bus.vga_req = 1'b0;
    tick();
    check("vg_rel_gnt", bus.vga_gnt, 0);
    check("vg_rel_rdy", bus.cpu_rdy, 1);

    // Simultaneous requests: VGA first, then direct hand-over to UART
    bus.vga_req = 1'b1; bus.uart_req = 1'b1; bus.cpu_sync = 1'b1;
    tick();
    check("sim_vgnt", bus.vga_gnt, 1);
    check("sim_ugnt", bus.uart_gnt, 0);
    check("sim_rdy", bus.cpu_rdy, 0);
    bus.cpu_sync = 1'b0; bus.vga_req = 1'b0;
    tick();
    check("ho_vgnt", bus.vga_gnt, 0);
    check("ho_ugnt", bus.uart_gnt, 1);
    check("ho_rdy", bus.cpu_rdy, 0);
    bus.uart_addr = 11'h600; bus.uart_wdata = 8'h3C; bus.uart_we = 1'b1;
    tick();
    bus.uart_we = 1'b0; bus.uart_req = 1'b0;
    tick();
    check("u_rel_gnt", bus.uart_gnt, 0);
    check("u_rel_rdy", bus.cpu_rdy, 1);
    bus.cpu_addr = 11'h600; bus.cpu_we = 1'b0;
    tick();
    check("u_readback", bus.cpu_rdata, 8'h3C);

    // Watchdog: SYNC never comes
    bus.uart_req = 1'b1;
    n = 0;
    while (bus.uart_gnt !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("wd_latency", n, 65);
    check("wd_rdy", bus.cpu_rdy, 0);
    bus.uart_req = 1'b0;
    tick();
    check("wd_rel_rdy", bus.cpu_rdy, 1);

    // Reset in the middle of a UART write burst
    bus.uart_req = 1'b1; bus.cpu_sync = 1'b1;
    tick();
    check("mr_ugnt", bus.uart_gnt, 1);
    bus.cpu_sync = 1'b0; bus.uart_we = 1'b1; bus.uart_addr = 11'h10;
    reset = 1'b1;
    tick();
    check("mr_ugnt0", bus.uart_gnt, 0);
    check("mr_ram_we", bus.ram_we, 0);
    check("mr_rdy", bus.cpu_rdy, 0);
    reset = 1'b0; bus.uart_req = 1'b0; bus.uart_we = 1'b0;
    tick();
    check("mr_run_rdy", bus.cpu_rdy, 1);

    // Vector table, one clock per row
    for (int i = 0; i < 13; i++) begin
      reset         = vecs[i].rst;
      bus.cpu_sync  = vecs[i].sync;
      bus.vga_req   = vecs[i].vreq;
      bus.uart_req  = vecs[i].ureq;
      bus.cpu_we    = vecs[i].cwe;
      bus.uart_we   = vecs[i].uwe;
      tick();
      check($sformatf("v%0d_rdy", i), bus.cpu_rdy, vecs[i].rdy);
      check($sformatf("v%0d_vgnt", i), bus.vga_gnt, vecs[i].vg);
      check($sformatf("v%0d_ugnt", i), bus.uart_gnt, vecs[i].ug);
      check($sformatf("v%0d_rvalid", i), bus.vga_rvalid, vecs[i].rv);
      check($sformatf("v%0d_ram_we", i), bus.ram_we, vecs[i].we);
    end

    // Random traffic: exclusive ownership and legal writes every cycle
    for (int i = 0; i < 10000; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus.cpu_sync   = 1'($urandom_range(0, 1));
      bus.cpu_we     = 1'($urandom_range(0, 1));
      bus.uart_we    = 1'($urandom_range(0, 1));
      bus.vga_req    = ($urandom_range(0, 3) != 0) ? bus.vga_req : ~bus.vga_req;
      bus.uart_req   = ($urandom_range(0, 3) != 0) ? bus.uart_req : ~bus.uart_req;
      bus.cpu_addr   = 11'($urandom);
      bus.vga_addr   = 11'($urandom);
      bus.uart_addr  = 11'($urandom);
      bus.cpu_wdata  = 8'($urandom);
      bus.uart_wdata = 8'($urandom);
      tick();
      check("rnd_onehot", 32'($countones({bus.cpu_rdy, bus.vga_gnt, bus.uart_gnt})) <= 1, 1);
      ok = !bus.ram_we || (bus.cpu_rdy && bus.cpu_we) || (bus.uart_gnt && bus.uart_we);
      check("rnd_we_legal", ok, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Time-shares the single 2 KiB system RAM (one read port, one write port, registered read) between three requesters: the 6502 core, the VGA renderer and the UART program loader.
- The CPU is the default owner. It is paused through its RDY input, and only at an instruction boundary (SYNC).
- Replaces the inline cpu_ready logic and address/data muxes in the top level with one verifiable block. Adds explicit grants, fixed priority and a SYNC watchdog.

Parameters:
- ADDR_W, 11, RAM address width; requester addresses are truncated to this width.
- SYNC_TIMEOUT, 64, maximum cycles to wait for cpu_sync before forcing a hand-over. Legal range 1..255.

Ports:
- clk  in  1  system clock (25 MHz domain); single clock.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  CPU address bus (combinational from core).
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_sync  in  1  CPU starting a new instruction.
- cpu_rdy  out  1  CPU ready; 0 pauses the core.
- cpu_rdata  out  8  read data to CPU (= ram_dout).
- vga_req  in  1  VGA wants the RAM; held high for the whole burst.
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  VGA owns the RAM.
- vga_rvalid  out  1  vga_rdata holds data for the vga_addr presented on the previous granted cycle.
- vga_rdata  out  8  read data to VGA (= ram_dout).
- uart_req  in  1  UART loader wants the RAM.
- uart_addr  in  ADDR_W  UART write address.
- uart_wdata  in  8  UART write data.
- uart_we  in  1  UART write strobe.
- uart_gnt  out  1  UART owns the RAM.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_din  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  8  RAM read data; valid one cycle after ram_raddr.

Behaviour:
- States: RST, RUN, WAIT_SYNC, VGA, UART. The state register and cpu_rdy/vga_gnt/uart_gnt are registered. RAM-side muxes are combinational from the registered state.
- Reset (any cycle, including mid-grant): next edge gives state=RST, cpu_rdy=0, vga_gnt=0, uart_gnt=0, vga_rvalid=0, watchdog=0. ram_we must be 0 whenever state=RST.
- RST -> RUN on the first edge with reset=0. cpu_rdy=1 in the same cycle.
- RUN (cpu_rdy=1): RAM ports carry the cpu_* signals; ram_we = cpu_we.
  - If a request is pending and cpu_sync=1, go to the grant state. VGA has priority over UART.
  - If a request is pending and cpu_sync=0, go to WAIT_SYNC.
- WAIT_SYNC: cpu_rdy stays 1 and the CPU keeps the RAM. An 8-bit watchdog increments each cycle.
  - Leave on cpu_sync=1, or when the watchdog reaches SYNC_TIMEOUT-1. Either way, go to the grant state selected by priority re-evaluated that cycle.
  - If all requests have dropped, return to RUN.
  - The watchdog clears on leaving WAIT_SYNC.
- Grant entry: cpu_rdy=0 and the chosen gnt=1 from the cycle after the decision edge. The CPU therefore executes the SYNC cycle, then freezes.
- VGA state: ram_raddr = vga_addr; ram_we = 0. vga_rvalid is gnt delayed by one cycle.
- UART state: ram_waddr = ram_raddr = uart_addr; ram_din = uart_wdata; ram_we = uart_we.
- Release: when the owner's req is 0 at an edge, its gnt falls next cycle.
  - If the other request is pending, hand over directly: the other gnt rises in that same next cycle and the CPU stays paused, since it is still at an instruction boundary.
  - Otherwise go to RUN with cpu_rdy=1.
- No preemption: a granted owner keeps the RAM while its req is high, even if a higher-priority request arrives.
- Simultaneous vga_req and uart_req at decision time: VGA wins; UART is served after VGA releases.
- At most one of cpu_rdy, vga_gnt, uart_gnt is high in any cycle. All are 0 in RST.
- cpu_rdata and vga_rdata are both wired to ram_dout. Each consumer qualifies the data with its own rdy or rvalid.

Test Plan:
- Reset 3 cycles, then release -> cpu_rdy=0 during reset and 1 on the cycle after release; grants 0; ram_we follows cpu_we.
- In RUN, vga_req=1 with cpu_sync=0 for 5 cycles, then 1 -> cpu_rdy stays 1 through the sync cycle; next cycle cpu_rdy=0, vga_gnt=1. Drive vga_addr=0x200 holding 0xA5 -> next cycle vga_rvalid=1, vga_rdata=0xA5.
- vga_req and uart_req rise together, cpu_sync=1 -> vga_gnt first. Drop vga_req -> next cycle vga_gnt=0, uart_gnt=1, cpu_rdy stays 0. UART writes 0x3C to 0x600 -> readback via CPU is 0x3C after uart_req drops and cpu_rdy returns to 1.
- uart_req=1 with cpu_sync held 0 and SYNC_TIMEOUT=64 -> uart_gnt rises exactly 65 cycles after request (64 in WAIT_SYNC plus grant).
- Reset asserted mid-UART burst with uart_we=1 -> next cycle uart_gnt=0, ram_we=0, cpu_rdy=0; after release, RUN.
- Random request/sync stimulus for 10k cycles -> assertion that cpu_rdy, vga_gnt and uart_gnt are one-hot-or-zero, and that ram_we=1 only when cpu_rdy·cpu_we or uart_gnt·uart_we holds.
